// File: rtl/ascon_finalize.sv
// Ascon-128 finalization: key into capacity, p^ROUNDS, tag = x3/x4 ^ K,
// constant-time comparison of the computed tag against the received tag.

module ascon_permutation #(
   parameter int ROUNDS = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [0:4][63:0] state_in,
   output logic [0:4][63:0] state_out,
   output logic             done
);

   localparam logic [3:0] LAST  = 4'(ROUNDS);
   localparam logic [3:0] FIRST = 4'(12 - ROUNDS);

   logic [0:4][63:0] st;
   logic [3:0]       cnt;
   logic             run;

   function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // p^a uses the last a constants of the 12-entry schedule
   function automatic logic [7:0] rc(input logic [3:0] i);
      logic [3:0] r;
      r = FIRST + i;
      return {~r, r};
   endfunction

   function automatic logic [0:4][63:0] round_fn(input logic [0:4][63:0] s,
                                                 input logic [7:0]       c);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      logic [0:4][63:0] r;
      x0 = s[0];
      x1 = s[1];
      x2 = s[2] ^ {56'd0, c};
      x3 = s[3];
      x4 = s[4];
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      r[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      r[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      r[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      r[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      r[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return r;
   endfunction

   // Round 0 is applied on the start edge, so done rises ROUNDS cycles later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st  <= '0;
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         st  <= round_fn(state_in, rc(4'd0));
         cnt <= 4'd1;
         run <= 1'b1;
      end else if (run) begin
         if (cnt == LAST) begin
            run <= 1'b0;
         end else begin
            st  <= round_fn(st, rc(cnt));
            cnt <= cnt + 4'd1;
         end
      end
   end

   assign state_out = st;
   assign done      = run && (cnt == LAST);

endmodule

module ascon_finalize #(
   parameter int ROUNDS = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [0:4][63:0] state_in,
   input  logic [127:0]     key,
   input  logic [127:0]     tag_in,
   output logic [127:0]     tag_out,
   output logic             tag_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      IDLE,
      KEY_XOR,
      PERM_START,
      PERM_WAIT,
      COMPARE,
      DONE
   } state_t;

   state_t           state, state_nxt;
   logic [0:4][63:0] st;
   logic [127:0]     key_r;
   logic [127:0]     tag_r;
   logic             perm_start;
   logic             perm_done;
   logic [0:4][63:0] perm_state;

   ascon_permutation #(.ROUNDS(ROUNDS)) u_perm (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (perm_start),
      .state_in  (st),
      .state_out (perm_state),
      .done      (perm_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      perm_start = 1'b0;
      case (state)
         IDLE:       if (start) state_nxt = KEY_XOR;
         KEY_XOR:    state_nxt = PERM_START;
         PERM_START: begin
            perm_start = 1'b1;
            state_nxt  = PERM_WAIT;
         end
         PERM_WAIT:  if (perm_done) state_nxt = COMPARE;
         COMPARE:    state_nxt = DONE;
         DONE:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= '0;
         key_r     <= '0;
         tag_r     <= '0;
         tag_out   <= '0;
         tag_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  st        <= state_in;
                  key_r     <= key;
                  tag_r     <= tag_in;
                  busy      <= 1'b1;
                  tag_valid <= 1'b0;
                  tag_out   <= '0;
               end
            end
            KEY_XOR: begin
               st[1] <= st[1] ^ key_r[127:64];
               st[2] <= st[2] ^ key_r[63:0];
            end
            PERM_WAIT: begin
               if (perm_done) begin
                  st      <= perm_state;
                  tag_out <= {perm_state[3] ^ key_r[127:64], perm_state[4] ^ key_r[63:0]};
               end
            end
            COMPARE: begin
               // full-width reduce, no data-dependent early exit
               tag_valid <= ~|(tag_out ^ tag_r);
               done      <= 1'b1;
            end
            DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ascon_finalize.sv
// Directed/randomized bench for ascon_finalize against an S-box-table model
// of Ascon-128 finalization.

module tb_ascon_finalize;

   localparam int P = 12;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [0:4][63:0] state_in;
   logic [127:0]     key;
   logic [127:0]     tag_in;
   logic [127:0]     tag_out;
   logic             tag_valid;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [4:0] sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                             5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                             5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                             5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   int rot_a [5] = '{19, 61, 1, 10, 7};
   int rot_b [5] = '{28, 39, 6, 17, 41};

   ascon_finalize #(.ROUNDS(P)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .state_in  (state_in),
      .key       (key),
      .tag_in    (tag_in),
      .tag_out   (tag_out),
      .tag_valid (tag_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // column-wise 5-bit S-box lookup, x0 is the MSB of each column index
   function automatic logic [127:0] model_tag(input logic [0:4][63:0] s, input logic [127:0] k);
      logic [63:0] x [5];
      logic [4:0]  col;
      for (int i = 0; i < 5; i++) x[i] = s[i];
      x[1] ^= k[127:64];
      x[2] ^= k[63:0];
      for (int r = 0; r < 12; r++) begin
         x[2] ^= 64'(((15 - r) << 4) | r);
         for (int b = 0; b < 64; b++) begin
            col = sbox[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
            x[0][b] = col[4];
            x[1][b] = col[3];
            x[2][b] = col[2];
            x[3][b] = col[1];
            x[4][b] = col[0];
         end
         for (int i = 0; i < 5; i++) x[i] = x[i] ^ rotr(x[i], rot_a[i]) ^ rotr(x[i], rot_b[i]);
      end
      return {x[3] ^ k[127:64], x[4] ^ k[63:0]};
   endfunction

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [0:4][63:0] rstate();
      logic [0:4][63:0] s;
      for (int i = 0; i < 5; i++) s[i] = r64();
      return s;
   endfunction

   task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", name, obs, exp);
   endtask

   // One full operation; inject=1 pulses start with junk inputs in KEY_XOR and PERM_WAIT.
   task automatic run_op(input string name, input logic [0:4][63:0] s, input logic [127:0] k,
                         input logic [127:0] t, input bit inject);
      int          lat;
      int          ps;
      bit          busy_ok;
      logic [127:0] exp_tag;
      exp_tag  = model_tag(s, k);
      state_in = s;
      key      = k;
      tag_in   = t;
      start    = 1'b1;
      lat      = 0;
      ps       = 0;
      busy_ok  = 1'b1;
      for (int c = 1; c <= 60 && lat == 0; c++) begin
         @(posedge clk); #1;
         start = inject && (c == 1 || c == 5);
         if (start) begin
            state_in = rstate();
            key      = {r64(), r64()};
            tag_in   = {r64(), r64()};
         end
         if (dut.perm_start === 1'b1) ps++;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) lat = c;
      end
      start = 1'b0;
      check({name, " latency"}, 128'(lat), 128'(4 + P));
      check({name, " tag_out"}, tag_out, exp_tag);
      check({name, " tag_valid"}, 128'(tag_valid), 128'(t == exp_tag));
      check({name, " perm_start pulses"}, 128'(ps), 128'd1);
      check({name, " busy through done"}, 128'(busy_ok), 128'd1);
      @(posedge clk); #1;
      check({name, " done after"}, 128'(done), 128'd0);
      check({name, " busy after"}, 128'(busy), 128'd0);
      check({name, " tag held"}, tag_out, exp_tag);
   endtask

   initial begin
      logic [0:4][63:0] gs, zs;
      logic [127:0]     gk, gt, zt;
      logic [0:4][63:0] hs [3];
      logic [127:0]     hk [3];
      logic [127:0]     ht [3];
      int               dn [$];
      bit               seen_done, seen_busy;

      rst_n    = 1'b0;
      start    = 1'b0;
      state_in = '0;
      key      = '0;
      tag_in   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset tag_out", tag_out, '0);
      check("reset flags", {tag_valid, busy, done}, '0);
      rst_n = 1'b1;

      // asynchronous reset while the permutation is running
      @(posedge clk); #1;
      state_in = rstate();
      key      = {r64(), r64()};
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check("busy before reset", 128'(busy), 128'd1);
      rst_n = 1'b0;
      #1;
      check("async reset tag_out", tag_out, '0);
      check("async reset flags", {tag_valid, busy, done}, '0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      seen_done = 1'b0;
      seen_busy = 1'b0;
      for (int c = 0; c < 24; c++) begin
         @(posedge clk); #1;
         if (done !== 1'b0) seen_done = 1'b1;
         if (busy !== 1'b0) seen_busy = 1'b1;
      end
      check("idle after reset done", 128'(seen_done), 128'd0);
      check("idle after reset busy", 128'(seen_busy), 128'd0);

      gs[0] = 64'h0123456789ABCDEF;
      gs[1] = 64'hFEDCBA9876543210;
      gs[2] = 64'h0011223344556677;
      gs[3] = 64'h8899AABBCCDDEEFF;
      gs[4] = 64'hDEADBEEFCAFEBABE;
      gk    = 128'h000102030405060708090A0B0C0D0E0F;
      gt    = model_tag(gs, gk);
      run_op("golden", gs, gk, gt, 1'b0);
      run_op("flip bit0", gs, gk, gt ^ 128'd1, 1'b0);
      run_op("flip bit127", gs, gk, gt ^ {1'b1, 127'd0}, 1'b0);
      run_op("tag zero", gs, gk, '0, 1'b0);
      run_op("start ignored", gs, gk, gt, 1'b1);

      zs = '0;
      zt = model_tag(zs, '0);
      run_op("zero vector", zs, '0, zt, 1'b0);

      for (int i = 0; i < 4; i++) begin
         logic [0:4][63:0] s;
         logic [127:0]     k, t;
         s = rstate();
         k = {r64(), r64()};
         t = (i % 2 == 0) ? model_tag(s, k) : model_tag(s, k) ^ (128'd1 << $urandom_range(127));
         run_op("random", s, k, t, 1'b0);
      end

      // start held high across three back-to-back operations
      for (int i = 0; i < 3; i++) begin
         hs[i] = rstate();
         hk[i] = {r64(), r64()};
         ht[i] = (i == 1) ? {r64(), r64()} : model_tag(hs[i], hk[i]);
      end
      state_in = hs[0];
      key      = hk[0];
      tag_in   = ht[0];
      start    = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            dn.push_back(c);
            if (dn.size() <= 3) begin
               check("b2b tag_out", tag_out, model_tag(hs[dn.size() - 1], hk[dn.size() - 1]));
               check("b2b tag_valid", 128'(tag_valid),
                     128'(ht[dn.size() - 1] == model_tag(hs[dn.size() - 1], hk[dn.size() - 1])));
            end
            if (dn.size() >= 3) begin
               start = 1'b0;
            end else begin
               state_in = hs[dn.size()];
               key      = hk[dn.size()];
               tag_in   = ht[dn.size()];
            end
         end
      end
      start = 1'b0;
      check("b2b done count", 128'(dn.size()), 128'd3);
      if (dn.size() == 3) begin
         check("b2b first done", 128'(dn[0]), 128'(4 + P));
         check("b2b gap 1", 128'(dn[1] - dn[0]), 128'(5 + P));
         check("b2b gap 2", 128'(dn[2] - dn[1]), 128'(5 + P));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ascon_finalize.md
Name: ascon_finalize

Overview:
Ascon-128 finalization stage, directly downstream of the decryption datapath. Consumes the 320-bit state left after the last ciphertext block, XORs the key into the capacity, runs p^12 through an ascon_permutation instance, and forms the 128-bit tag. Compares the computed tag against the received tag in constant time and reports authentication pass/fail. Plaintext release upstream is gated on tag_valid.

Parameters:
ROUNDS, 12, round count passed to the ascon_permutation instance (p^a for Ascon-128).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
state_in  input  5x64  state after ciphertext processing, words [0:4], word 0 = rate
key  input  128  K; key[127:64] = high word, key[63:0] = low word
tag_in  input  128  received tag to verify
tag_out  output  128  computed tag
tag_valid  output  1  1 = tag_out == tag_in; meaningful when done=1
busy  output  1  high from accepted start through DONE
done  output  1  one-cycle completion pulse

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: tag_out=0, tag_valid=0, busy=0, done=0, internal state and latched inputs=0, FSM=IDLE, perm_start=0. rst_n also resets the permutation instance.
- Reset mid-operation: abort immediately, no done pulse. A later start runs cleanly.
- FSM states: IDLE -> KEY_XOR -> PERM_START -> PERM_WAIT -> COMPARE -> DONE -> IDLE.
- IDLE: when start=1, latch state_in, key and tag_in; set busy=1, tag_valid=0, tag_out=0; go to KEY_XOR. When start=0, stay in IDLE and hold outputs.
- KEY_XOR: state[1] ^= key[127:64]; state[2] ^= key[63:0]; state[0], state[3] and state[4] are unchanged.
- PERM_START: perm_start is combinational = (FSM==PERM_START), so it is exactly one cycle wide. The permutation's state_in is driven from the internal state register.
- PERM_WAIT: wait for perm_done, with no timeout. On the first cycle perm_done=1:
  - capture perm_state into the internal state;
  - tag_out <= {perm_state[3]^key[127:64], perm_state[4]^key[63:0]};
  - go to COMPARE.
  - A perm_done seen in any other state is ignored.
- COMPARE: tag_valid <= ~|(tag_out ^ tag_in_latched). This is a full 128-bit XOR/OR-reduce with no early exit. Set done <= 1 and go to DONE.
- DONE: done=1 for exactly this cycle. Next cycle: done=0, busy=0, FSM=IDLE.
- Output hold: tag_out and tag_valid stay stable from DONE until the next accepted start.
- Latency: start accepted at cycle 0. perm_start is high at cycle 2. If perm_done is sampled at cycle 2+P, done is high at cycle 4+P.
- Start while busy (any state other than IDLE) is ignored. It is not queued, and inputs are not re-latched.
- Start held high continuously: a new operation begins the cycle after DONE. This is back-to-back with no idle gap beyond the IDLE acceptance cycle.
- Input changes after the acceptance cycle do not affect the result (inputs are latched).
- tag_valid is never 1 when done=0 after a fresh start. It is cleared at acceptance.

Test Plan:
- Reset with rst_n=0 during PERM_WAIT (state_in random) -> all outputs 0 immediately and asynchronously; after release with start=0, FSM stays IDLE with busy=0 and done=0.
- Golden check, state_in words = 64'h0123456789ABCDEF..., key = 128'h000102030405060708090A0B0C0D0E0F, tag_in = software-model tag -> done pulses exactly once at cycle 4+P, tag_out == model tag, tag_valid=1.
- Same stimulus with tag_in bit 0 flipped -> tag_valid=0, tag_out unchanged. Repeat with bit 127 flipped -> tag_valid=0. Repeat with tag_in = 0 -> tag_valid=0.
- Assert start again in KEY_XOR and in PERM_WAIT with different state_in/key -> ignored: result matches the first request, only one done pulse, perm_start is high for exactly one cycle per operation.
- Hold start=1 for three operations while changing inputs each run -> three done pulses, each exactly 1 cycle wide, spaced 5+P cycles apart, each tag matching its own latched inputs.
- Zero vector: state_in all 0, key 0, tag_in = model tag of p^12(0)[3:4] -> tag_valid=1. Check that busy is high from cycle 0 through the DONE cycle and low otherwise.
